i2c_regbank: RTL



---
 rtl/i2c_regbank_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/i2c_regbank.sv | 121 ++++++++++++
 3 files changed

// File: rtl/i2c_regbank_pkg.sv
// Shared address map and STATUS layout for the I2C register bank.
// Also has a helper that clamps the mailbox count to the 4-bit STATUS field.
package i2c_regbank_pkg;

  localparam logic [7:0] ADDR_ID     = 8'h10;
  localparam logic [7:0] ADDR_STATUS = 8'h11;
  localparam logic [7:0] ADDR_MBOX   = 8'h13;

  localparam int STAT_UNDERRUN  = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_COUNT_LSB = 4;

  // STATUS reports the count in 4 bits; a 16-deep mailbox can hold 16 bytes.
  function automatic logic [3:0] sat_count(input logic [4:0] c);
    return (c > 5'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a head-of-queue output and a synchronous active-low flush.
// A push while full and a pop while empty are both ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_regbank.sv
// Byte-wide register bank behind the I2C slave: config registers, ID, STATUS, mailbox.
// Define I2C_REGBANK_MBOX_EN to build the application-to-I2C mailbox FIFO.
module i2c_regbank
  import i2c_regbank_pkg::*;
#(
  parameter int          NUM_REGS   = 8,
  parameter logic [7:0]  DEVICE_ID  = 8'hA5,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rw,
  input  logic [7:0]            addr,
  input  logic                  wen,
  input  logic [7:0]            wdata,
  input  logic                  rdata_used,
  output logic [7:0]            rdata,
  output logic [8*NUM_REGS-1:0] cfg,
  output logic                  cfg_wr,
  input  logic [7:0]            mb_data,
  input  logic                  mb_valid,
  output logic                  mb_ready
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  logic       cfg_hit;
  logic [7:0] status_value;
  logic [7:0] mbox_value;
  logic [7:0] rd_value;

  assign cfg_hit = wen && (addr < NUM_REGS_B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg    <= '0;
      cfg_wr <= 1'b0;
    end else begin
      cfg_wr <= cfg_hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wen && addr == 8'(i)) cfg[8*i +: 8] <= wdata;
      end
    end
  end

`ifdef I2C_REGBANK_MBOX_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_req;
  logic          underrun;

  assign pop_req  = rdata_used && rw && (addr == ADDR_MBOX);
  assign mb_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mb_valid && mb_ready),
    .push_data (mb_data),
    .pop       (pop_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Setting takes priority so an underrun is never lost to a racing clear.
  always_ff @(posedge clk) begin
    if (!rst_n)                                             underrun <= 1'b0;
    else if (pop_req && fifo_empty)                         underrun <= 1'b1;
    else if (wen && addr == ADDR_STATUS && wdata[STAT_UNDERRUN]) underrun <= 1'b0;
  end

  always_comb begin
    status_value = '0;
    status_value[STAT_COUNT_LSB +: 4] = sat_count(5'(fifo_count));
    status_value[STAT_FULL]           = fifo_full;
    status_value[STAT_EMPTY]          = fifo_empty;
    status_value[STAT_UNDERRUN]       = underrun;
  end

  assign mbox_value = fifo_empty ? 8'h00 : fifo_head;
`else
  logic unused_mbox;

  assign unused_mbox = ^{mb_data, mb_valid, rdata_used, rw};
  assign mb_ready    = 1'b0;
  assign mbox_value  = 8'h00;

  always_comb begin
    status_value = '0;
    status_value[STAT_EMPTY] = 1'b1;
  end
`endif

  always_comb begin
    rd_value = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 8'(i)) rd_value = cfg[8*i +: 8];
    end
    case (addr)
      ADDR_ID:     rd_value = DEVICE_ID;
      ADDR_STATUS: rd_value = status_value;
      ADDR_MBOX:   rd_value = mbox_value;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= 8'h00;
    else        rdata <= rd_value;
  end

endmodule
